// File: rtl/recv_protocol_pkg.sv
// -----------------------------------------------------------------------------
// recv_protocol_pkg
// Constants and types shared by the token-ring serial transmitter and the
// receiver. Both ends import this package, so the payload width and the start
// pattern cannot drift apart.
//   DATA_W    : payload width in bits
//   SEQ_W     : start-sequence length in bits
//   START_SEQ : start pattern; the leftmost bit is on the line first
//   CNT_W     : receive bit-counter width; it must be able to hold DATA_W
//   state_e   : receiver FSM states
// -----------------------------------------------------------------------------
package recv_protocol_pkg;

  localparam int DATA_W = 55;
  localparam int SEQ_W  = 6;
  localparam int CNT_W  = 6;

  localparam logic [SEQ_W-1:0] START_SEQ = 6'b011111;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    RECEIVE = 2'd1,
    STOP    = 2'd2
  } state_e;

endpackage : recv_protocol_pkg

// File: rtl/recv_protocol_if.sv
// -----------------------------------------------------------------------------
// recv_protocol_if
// Bundles the serial line and the router-side outputs of the receiver.
//   S_Data    : serial line; idles at 0
//   RX_Data   : last good payload; held between frames
//   valid     : one-cycle pulse when RX_Data updates
//   frame_err : one-cycle pulse on a bad stop bit
//   busy      : high while a frame is being received
// modport slave  - the receiver (samples S_Data, drives the rest)
// modport master - line driver / router side
// -----------------------------------------------------------------------------
interface recv_protocol_if;
  import recv_protocol_pkg::*;

  logic              S_Data;
  logic [DATA_W-1:0] RX_Data;
  logic              valid;
  logic              frame_err;
  logic              busy;

  modport slave (
    input  S_Data,
    output RX_Data,
    output valid,
    output frame_err,
    output busy
  );

  modport master (
    output S_Data,
    input  RX_Data,
    input  valid,
    input  frame_err,
    input  busy
  );

endinterface : recv_protocol_if

// File: rtl/recv_protocol_start_detect.sv
// -----------------------------------------------------------------------------
// start_detect
// Shift register that watches the serial line for START_SEQ.
//   clk     : system clock
//   rst     : asynchronous active-high reset
//   en_i    : shift the sampled bit in (only while hunting)
//   clr_i   : clear the history (takes priority over en_i)
//   bit_i   : bit sampled on this edge
//   match_o : combinational; high when the history plus bit_i equals START_SEQ
// -----------------------------------------------------------------------------
module start_detect
  import recv_protocol_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  input  logic bit_i,
  output logic match_o
);

  logic [SEQ_W-1:0] seq_q;
  logic [SEQ_W-1:0] seq_d;

  // The window includes the bit arriving on this edge, so the FSM can lock
  // on the same edge that samples the last start bit.
  logic [SEQ_W-1:0] window;
  assign window  = {seq_q[SEQ_W-2:0], bit_i};
  assign match_o = (window == START_SEQ);

  always_comb begin
    seq_d = seq_q;
    if (clr_i) begin
      seq_d = '0;
    end else if (en_i) begin
      seq_d = window;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_q <= '0;
    end else begin
      seq_q <= seq_d;
    end
  end

endmodule : start_detect

// File: rtl/recv_protocol.sv
// -----------------------------------------------------------------------------
// recv_protocol
// Serial receiver downstream of the token-ring transmitter (same clock).
// Hunts for START_SEQ, deserializes DATA_W bits MSB first, checks a stop bit
// that must be 0, then presents the word with a one-cycle valid strobe.
//   clk  : system clock, all state updates on the posedge
//   rst  : asynchronous active-high reset
//   bus  : recv_protocol_if.slave (S_Data in; RX_Data, valid, frame_err,
//          busy out)
// -----------------------------------------------------------------------------
module recv_protocol
  import recv_protocol_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  recv_protocol_if.slave  bus
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [DATA_W-1:0]   rx_q, rx_d;
  logic                valid_q, valid_d;
  logic                ferr_q, ferr_d;
  logic                busy_q, busy_d;

  logic                det_en;
  logic                det_clr;
  logic                det_match;
  logic                b;

  // The line comes from a registered transmitter output on the same clock,
  // so it is used directly without a synchronizer.
  assign b = bus.S_Data;

  start_detect u_start_detect (
    .clk     (clk),
    .rst     (rst),
    .en_i    (det_en),
    .clr_i   (det_clr),
    .bit_i   (b),
    .match_o (det_match)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    rx_d    = rx_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    det_en  = 1'b0;
    det_clr = 1'b0;

    case (state_q)
      HUNT: begin
        det_en = 1'b1;
        if (det_match) begin
          state_d = RECEIVE;
          cnt_d   = CNT_W'(DATA_W);
        end
      end

      RECEIVE: begin
        // Detector stays frozen here, so payload runs of 011111 cannot
        // cause a resync.
        data_d = {data_q[DATA_W-2:0], b};
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = STOP;
        end
      end

      STOP: begin
        // Clearing the history lets the next 011111 lock without needing
        // any particular idle pattern first.
        det_clr = 1'b1;
        state_d = HUNT;
        if (!b) begin
          rx_d    = data_q;
          valid_d = 1'b1;
        end else begin
          ferr_d  = 1'b1;
        end
      end

      default: begin
        det_clr = 1'b1;
        state_d = HUNT;
      end
    endcase

    // Registered from the next state so busy tracks the state register
    // exactly, cycle for cycle.
    busy_d = (state_d == RECEIVE) || (state_d == STOP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HUNT;
      cnt_q   <= '0;
      data_q  <= '0;
      rx_q    <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      rx_q    <= rx_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.RX_Data   = rx_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.busy      = busy_q;

endmodule : recv_protocol

// File: tb/tb_recv_protocol.sv
// -----------------------------------------------------------------------------
// tb_recv_protocol
// Directed bench for recv_protocol. A behavioural line driver plays the
// transmitter; each frame sent pushes its expected outcome (kind, payload,
// pulse edge) onto a scoreboard queue that a negedge monitor pops whenever
// valid or frame_err is seen.
// -----------------------------------------------------------------------------
module tb_recv_protocol;
  import recv_protocol_pkg::*;

  typedef struct {
    logic              err;
    logic [DATA_W-1:0] payload;
    int                edge_no;
  } exp_t;

  logic clk;
  logic rst;

  recv_protocol_if bus_if ();

  recv_protocol dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   vectors    = 0;
  int   miscompares = 0;
  int   edge_cnt   = 0;
  logic prev_pulse = 1'b0;
  logic [DATA_W-1:0] last_good = '0;
  exp_t sb_q[$];

  always @(posedge clk) edge_cnt++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Scoreboard monitor: every pulse must match the oldest outstanding frame.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (bus_if.valid || bus_if.frame_err) begin
        chk("pulse_exclusive", 64'(bus_if.valid & bus_if.frame_err), 64'd0);
        chk("pulse_consecutive", 64'(prev_pulse), 64'd0);
        if (sb_q.size() == 0) begin
          chk("unexpected_pulse", 64'd1, 64'd0);
        end else begin
          e = sb_q.pop_front();
          chk("pulse_kind", 64'({bus_if.valid, bus_if.frame_err}),
              e.err ? 64'd1 : 64'd2);
          chk("pulse_edge", 64'(edge_cnt), 64'(e.edge_no));
          chk("rx_data", 64'(bus_if.RX_Data), 64'(e.payload));
        end
      end
      prev_pulse = bus_if.valid | bus_if.frame_err;
    end else begin
      prev_pulse = 1'b0;
    end
  end

  task automatic drive_bit(input logic bv);
    @(negedge clk);
    bus_if.S_Data = bv;
  endtask

  // Emulates the transmitter: start sequence, payload MSB first, stop bit,
  // then two idle zeros (DONE, WAIT).
  task automatic send_frame(input logic [DATA_W-1:0] payload, input logic stop_bit);
    exp_t e;
    logic [SEQ_W-1:0] st;
    st = START_SEQ;
    for (int i = 0; i < SEQ_W; i++) begin
      @(negedge clk);
      if (i == 0) begin
        chk("busy_idle", 64'(bus_if.busy), 64'd0);
        // Start bit goes out on the next posedge (E0); pulse follows E61.
        e.edge_no = edge_cnt + 1 + 61;
        e.err     = stop_bit;
        e.payload = stop_bit ? last_good : payload;
        sb_q.push_back(e);
        if (!stop_bit) last_good = payload;
      end
      bus_if.S_Data = st[SEQ_W-1-i];
    end
    for (int i = 0; i < DATA_W; i++) begin
      @(negedge clk);
      if (i == 0) chk("busy_receive", 64'(bus_if.busy), 64'd1);
      bus_if.S_Data = payload[DATA_W-1-i];
    end
    drive_bit(stop_bit);
    @(negedge clk);
    chk("busy_after_stop", 64'(bus_if.busy), 64'd0);
    bus_if.S_Data = 1'b0;
    drive_bit(1'b0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rx"},    64'(bus_if.RX_Data),   64'd0);
    chk({tag, "_valid"}, 64'(bus_if.valid),     64'd0);
    chk({tag, "_ferr"},  64'(bus_if.frame_err), 64'd0);
    chk({tag, "_busy"},  64'(bus_if.busy),      64'd0);
  endtask

  initial begin
    logic [DATA_W-1:0] pl;
    logic [SEQ_W-1:0]  st;
    logic [5:0]        partial;

    rst = 1'b1;
    bus_if.S_Data = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;

    // Idle line: no pulses (monitor), busy stays low.
    repeat (100) drive_bit(1'b0);
    chk("idle_busy", 64'(bus_if.busy), 64'd0);

    send_frame(55'h12_3456_789A_BCDE, 1'b0);
    send_frame(55'h7F_FFFF_FFFF_FFFF, 1'b0);
    send_frame(55'h0F_BEFB_EFBE_FBEF, 1'b0);

    // Bad stop bit: frame_err, RX_Data keeps the previous payload.
    pl = {$urandom, $urandom};
    send_frame(pl, 1'b1);
    pl = {$urandom, $urandom};
    send_frame(pl, 1'b0);

    // Asynchronous reset mid-cycle: outputs clear before the next edge.
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_reset_outputs("async_rst");
    last_good = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) drive_bit(1'b0);

    // Frame aborted by reset after data bit 20: no pulse of either kind.
    st = START_SEQ;
    pl = 55'h55_AAAA_5555_AAAA;
    for (int i = 0; i < SEQ_W; i++) drive_bit(st[SEQ_W-1-i]);
    for (int i = 0; i < 21; i++) drive_bit(pl[DATA_W-1-i]);
    @(negedge clk);
    chk("abort_busy_before", 64'(bus_if.busy), 64'd1);
    #2 rst = 1'b1;
    #1 chk_reset_outputs("abort_rst");
    bus_if.S_Data = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) drive_bit(1'b0);

    // Partial start 0,1,1,1,1,0 must not lock.
    partial = 6'b011110;
    for (int i = 0; i < 6; i++) drive_bit(partial[5-i]);
    repeat (3) drive_bit(1'b0);
    chk("partial_no_lock", 64'(bus_if.busy), 64'd0);
    send_frame(55'h00_0000_0000_0001, 1'b0);

    // Three back-to-back frames with the minimum idle gap.
    for (int k = 0; k < 3; k++) begin
      pl = {$urandom, $urandom};
      send_frame(pl, 1'b0);
    end

    repeat (5) drive_bit(1'b0);
    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_recv_protocol
